// File: rtl/halton_nd_gen.sv
// rtl/halton_nd_gen.sv - N-channel Halton point generator with shared sequential divider
// One Van der Corput digit array per channel; a single Horner/divide datapath is time-shared.
module halton_nd_gen #(
   parameter int CHANNELS = 4,
   parameter int BASE_0   = 2,
   parameter int BASE_1   = 3,
   parameter int BASE_2   = 5,
   parameter int BASE_3   = 7,
   parameter int DIGITS   = 12,
   parameter int OUT_W    = 32,
   parameter int SEED_W   = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      pop_enable,
   input  logic                      reseed_enable,
   input  logic [SEED_W-1:0]         seed,
   input  logic                      out_ready,
   output logic [CHANNELS*OUT_W-1:0] out_data,
   output logic                      valid,
   output logic                      busy
);
   function automatic logic [63:0] ipow(input int b, input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'(b);
      return r;
   endfunction

   localparam int BASES [4] = '{BASE_0, BASE_1, BASE_2, BASE_3};
   localparam logic [63:0] DENS [4] = '{ipow(BASE_0, DIGITS), ipow(BASE_1, DIGITS),
                                        ipow(BASE_2, DIGITS), ipow(BASE_3, DIGITS)};
   localparam int MAX_CNT = (SEED_W > DIGITS) ? ((SEED_W > OUT_W) ? SEED_W : OUT_W)
                                              : ((DIGITS > OUT_W) ? DIGITS : OUT_W);
   localparam int CNT_W = $clog2(MAX_CNT + 1);

   generate
      if (CHANNELS < 1 || CHANNELS > 4) begin : g_bad_channels
         $error("CHANNELS must be 1..4");
      end
      for (genvar c = 0; c < CHANNELS; c++) begin : g_chk
         if (BASES[c] < 2 || BASES[c] > 15 || DENS[c] >= 64'h0001_0000_0000_0000) begin : g_bad_base
            $error("channel base out of range or BASE^DIGITS >= 2^48");
         end
      end
   endgenerate

   typedef enum logic [2:0] {S_IDLE, S_SEED, S_HORNER, S_DIVIDE, S_HOLD} state_t;

   state_t            state, state_next;
   logic [CNT_W-1:0]  cnt;
   logic [1:0]        ch;
   logic [SEED_W-1:0] seed_q;
   logic [48:0]       acc;
   logic [3:0]        dig     [CHANNELS][DIGITS];
   logic [3:0]        dig_dbl [CHANNELS][DIGITS];
   logic [3:0]        dig_inc [CHANNELS][DIGITS];
   logic [3:0]        cur_base, cur_dig;
   logic [48:0]       cur_den, acc_shl, acc_mac;
   logic              q_bit, seed_last, horner_last, div_last, ch_last;

   assign seed_last   = cnt == CNT_W'(SEED_W - 1);
   assign horner_last = cnt == CNT_W'(DIGITS - 1);
   assign div_last    = cnt == CNT_W'(OUT_W - 1);
   assign ch_last     = ch == 2'(CHANNELS - 1);
   assign cur_base    = 4'(BASES[ch]);
   assign cur_den     = 49'(DENS[ch]);
   // Remainder stays below den < 2^48, so bit 48 never carries information into the shift.
   assign acc_shl     = {acc[47:0], 1'b0};
   assign q_bit       = acc_shl >= cur_den;
   assign acc_mac     = ((cnt == '0) ? 49'd0 : acc) * 49'(cur_base) + 49'(cur_dig);

   always_comb begin
      cur_dig = '0;
      for (int c = 0; c < CHANNELS; c++)
         for (int i = 0; i < DIGITS; i++)
            if (int'(ch) == c && int'(cnt) == i) cur_dig = dig[c][i];
   end

   always_comb begin
      logic       dbl_c, inc_c;
      logic [4:0] t;
      dbl_c = 1'b0;
      inc_c = 1'b0;
      t     = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         dbl_c = seed_q[SEED_W-1];
         inc_c = 1'b1;
         for (int i = 0; i < DIGITS; i++) begin
            t = {dig[c][i], 1'b0} + 5'(dbl_c);
            if (t >= 5'(BASES[c])) begin
               dig_dbl[c][i] = 4'(t - 5'(BASES[c]));
               dbl_c = 1'b1;
            end else begin
               dig_dbl[c][i] = t[3:0];
               dbl_c = 1'b0;
            end
            t = 5'(dig[c][i]) + 5'(inc_c);
            if (t == 5'(BASES[c])) begin
               dig_inc[c][i] = 4'd0;
               inc_c = 1'b1;
            end else begin
               dig_inc[c][i] = t[3:0];
               inc_c = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      valid      = 1'b0;
      busy       = 1'b0;
      case (state)
         S_IDLE: begin
            if (reseed_enable)   state_next = S_SEED;
            else if (pop_enable) state_next = S_HORNER;
         end
         S_SEED: begin
            busy = 1'b1;
            if (seed_last) state_next = S_IDLE;
         end
         S_HORNER: begin
            busy = 1'b1;
            if (horner_last) state_next = S_DIVIDE;
         end
         S_DIVIDE: begin
            busy = 1'b1;
            if (div_last) state_next = ch_last ? S_HOLD : S_HORNER;
         end
         S_HOLD: begin
            valid = 1'b1;
            if (reseed_enable)  state_next = S_SEED;
            else if (out_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         ch       <= '0;
         seed_q   <= '0;
         acc      <= '0;
         out_data <= '0;
         for (int c = 0; c < CHANNELS; c++)
            for (int i = 0; i < DIGITS; i++) dig[c][i] <= '0;
      end else begin
         cnt <= (state_next != state) ? '0 : cnt + 1'b1;
         case (state)
            S_IDLE: begin
               if (reseed_enable) begin
                  seed_q <= seed;
                  for (int c = 0; c < CHANNELS; c++)
                     for (int i = 0; i < DIGITS; i++) dig[c][i] <= '0;
               end else if (pop_enable) begin
                  ch <= '0;
               end
            end
            S_SEED: begin
               seed_q <= seed_q << 1;
               dig    <= dig_dbl;
            end
            S_HORNER: acc <= acc_mac;
            S_DIVIDE: begin
               acc <= q_bit ? acc_shl - cur_den : acc_shl;
               for (int c = 0; c < CHANNELS; c++)
                  if (int'(ch) == c)
                     out_data[c*OUT_W +: OUT_W] <= {out_data[c*OUT_W +: OUT_W-1], q_bit};
               if (div_last) ch <= ch + 2'd1;
            end
            S_HOLD: begin
               if (reseed_enable) begin
                  seed_q <= seed;
                  for (int c = 0; c < CHANNELS; c++)
                     for (int i = 0; i < DIGITS; i++) dig[c][i] <= '0;
               end else if (out_ready) begin
                  dig <= dig_inc;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_halton_nd_gen.sv
// tb/tb_halton_nd_gen.sv - scoreboard bench for halton_nd_gen
// Reference model keeps each channel's index as an integer and computes the radical inverse arithmetically.
module tb_halton_nd_gen;
   localparam int CH  = 4;
   localparam int DIG = 12;
   localparam int OW  = 32;
   localparam int SW  = 32;
   localparam int LAT = CH * (DIG + OW);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n, pop_enable, reseed_enable, out_ready;
   logic [SW-1:0]     seed;
   logic [CH*OW-1:0]  out_data;
   logic              valid, busy;

   logic              pop2, reseed2, ready2;
   logic [SW-1:0]     seed2;
   logic [2*OW-1:0]   data2;
   logic              valid2, busy2;

   halton_nd_gen dut (
      .clk(clk), .rst_n(rst_n), .pop_enable(pop_enable), .reseed_enable(reseed_enable),
      .seed(seed), .out_ready(out_ready), .out_data(out_data), .valid(valid), .busy(busy)
   );

   halton_nd_gen #(.CHANNELS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .pop_enable(pop2), .reseed_enable(reseed2),
      .seed(seed2), .out_ready(ready2), .out_data(data2), .valid(valid2), .busy(busy2)
   );

   int               checks = 0;
   int               errors = 0;
   logic [CH*OW-1:0] exp_q [$];
   longint           idx [CH];
   int               bases [4] = '{2, 3, 5, 7};

   function automatic longint period(input int b);
      longint p;
      p = 1;
      for (int i = 0; i < DIG; i++) p = p * longint'(b);
      return p;
   endfunction

   function automatic logic [OW-1:0] vdc(input longint n, input int b);
      logic [127:0] rev, den;
      longint m;
      rev = '0;
      den = 128'd1;
      m   = n;
      for (int i = 0; i < DIG; i++) begin
         rev = rev * 128'(b) + 128'(m % longint'(b));
         m   = m / longint'(b);
         den = den * 128'(b);
      end
      return OW'((rev << OW) / den);
   endfunction

   function automatic logic [CH*OW-1:0] model_point();
      logic [CH*OW-1:0] p;
      for (int c = 0; c < CH; c++) p[c*OW +: OW] = vdc(idx[c], bases[c]);
      return p;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      logic [CH*OW-1:0] e;
      if (rst_n && valid && out_ready && !reseed_enable) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL point_unexpected actual=%h required=none", out_data);
         end else begin
            e = exp_q.pop_front();
            check("point", 128'(out_data), 128'(e));
         end
      end
   end

   // All driver tasks start and end 1 time unit after a rising edge.
   task automatic pop_wait();
      int   k;
      logic busy_ok;
      pop_enable = 1'b1;
      exp_q.push_back(model_point());
      @(posedge clk); #1;
      pop_enable = 1'b0;
      k = 0;
      busy_ok = 1'b1;
      while (!valid && k < LAT + 20) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk); #1;
         k++;
      end
      check("latency", 128'(k), 128'(LAT));
      check("busy_during_compute", 128'(busy_ok), 128'(1));
   endtask

   task automatic accept(input int hold);
      logic [CH*OW-1:0] snap;
      logic             stable;
      snap   = out_data;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         if (out_data !== snap || valid !== 1'b1 || busy !== 1'b0) stable = 1'b0;
      end
      if (hold > 0) check("hold_stable", 128'(stable), 128'(1));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("after_accept_valid_busy", 128'({valid, busy}), 128'(0));
      for (int c = 0; c < CH; c++) idx[c] = (idx[c] + 1) % period(bases[c]);
   endtask

   task automatic reseed(input logic [SW-1:0] s, input logic in_hold);
      int k;
      if (in_hold) begin
         void'(exp_q.pop_back());
         out_ready = 1'($urandom_range(0, 1));
      end
      reseed_enable = 1'b1;
      seed          = s;
      @(posedge clk); #1;
      reseed_enable = 1'b0;
      out_ready     = 1'b0;
      seed          = $urandom;
      check("seed_entry_valid_busy", 128'({valid, busy}), 128'(1));
      k = 0;
      while (busy && k < SW + 20) begin
         @(posedge clk); #1;
         k++;
      end
      check("seed_duration", 128'(k), 128'(SW));
      for (int c = 0; c < CH; c++) idx[c] = longint'(s) % period(bases[c]);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int r;
      rst_n = 1'b0; pop_enable = 1'b0; reseed_enable = 1'b0; out_ready = 1'b0; seed = '0;
      pop2 = 1'b0; reseed2 = 1'b0; ready2 = 1'b0; seed2 = '0;
      for (int c = 0; c < CH; c++) idx[c] = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_data", 128'(out_data), 128'(0));
      check("reset_valid_busy", 128'({valid, busy}), 128'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      pop_wait();
      check("point0_const", 128'(out_data), 128'(0));
      accept(0);
      pop_wait();
      check("point1_const", 128'(out_data), 128'h24924924_33333333_55555555_80000000);
      accept(0);
      pop_wait();
      check("point2_const", 128'(out_data), 128'h49249249_66666666_AAAAAAAA_40000000);
      accept(50);
      pop_wait();
      accept(0);

      reseed(32'd5, 1'b0);
      pop_wait();
      check("seed5_const", 128'(out_data), 128'hB6DB6DB6_0A3D70A3_C71C71C7_A0000000);
      accept(0);

      reseed(32'd4095, 1'b0);
      pop_wait();
      check("seed4095_ch0", 128'(out_data[OW-1:0]), 128'h FFF00000);
      accept(0);
      pop_wait();
      check("wrap_ch0", 128'(out_data[OW-1:0]), 128'(0));
      check("wrap_ch1_nonzero", 128'(out_data[2*OW-1:OW] != '0), 128'(1));
      accept(2);

      pop_wait();
      reseed($urandom, 1'b1);
      pop_wait();
      accept(1);

      for (int n = 0; n < 20; n++) begin
         r = int'($urandom_range(0, 4));
         if (r == 0) begin
            reseed(($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 5000)), 1'b0);
         end else begin
            pop_wait();
            if (r == 4) reseed($urandom, 1'b1);
            else        accept(int'($urandom_range(0, 4)));
         end
      end

      pop_wait();
      accept(0);
      pop_enable = 1'b1;
      @(posedge clk); #1;
      pop_enable = 1'b0;
      repeat (30) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_reset_out_data", 128'(out_data), 128'(0));
      check("mid_reset_valid_busy", 128'({valid, busy}), 128'(0));
      for (int c = 0; c < CH; c++) idx[c] = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      pop_wait();
      check("post_reset_point0", 128'(out_data), 128'(0));
      accept(0);

      pop2 = 1'b1;
      @(posedge clk); #1;
      pop2 = 1'b0;
      k = 0;
      while (!valid2 && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      check("ch2_latency", 128'(k), 128'(2 * (DIG + OW)));
      check("ch2_point0", 128'(data2), 128'(0));
      ready2 = 1'b1;
      @(posedge clk); #1;
      ready2 = 1'b0;
      pop2   = 1'b1;
      @(posedge clk); #1;
      pop2 = 1'b0;
      k = 0;
      while (!valid2 && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      check("ch2_point1", 128'(data2), 128'h55555555_80000000);

      check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
